// File: rtl/vga_scan_reader_if.sv
// Pixel-RAM read port plus video output bundle of the VGA scan reader.
// master = the scan reader, slave = RAM / display side.
interface vga_scan_reader_if;
    logic [11:0] din;
    logic [6:0]  col_addr;
    logic [5:0]  row_addr;
    logic        read_en;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_start;

    modport master (
        input  din,
        output col_addr, row_addr, read_en, hs, vs, r, g, b, frame_start
    );

    modport slave (
        output din,
        input  col_addr, row_addr, read_en, hs, vs, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_scan_reader.sv
// VGA raster generator that reads 8x8-pixel blocks from a pixel RAM and
// presents colour with hs/vs/frame_start delayed to line up with it.
module vga_scan_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RAM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    vga_scan_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int L       = 2 + RAM_LAT;

    // Counters are 10 bits so the block address is always a fixed bit slice.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]   h_cnt_r;
    logic [9:0]   v_cnt_r;
    logic         visible_s;
    logic         hs_raw_s;
    logic         vs_raw_s;
    logic         first_px_s;
    logic [6:0]   col_addr_r;
    logic [5:0]   row_addr_r;
    logic         read_en_r;
    logic [L-2:0] vis_dl_r;
    logic [L-1:0] hs_dl_r;
    logic [L-1:0] vs_dl_r;
    logic [L-1:0] fs_dl_r;
    logic [3:0]   r_r;
    logic [3:0]   g_r;
    logic [3:0]   b_r;

    // Raster position: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Decode of the current raster position.
    always_comb begin
        visible_s  = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        hs_raw_s   = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
        vs_raw_s   = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
        first_px_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    end

    // Block address stage; addresses freeze outside the visible area.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_addr_r <= 7'd0;
            row_addr_r <= 6'd0;
            read_en_r  <= 1'b0;
        end else begin
            read_en_r <= visible_s;
            if (visible_s) begin
                col_addr_r <= h_cnt_r[9:3];
                row_addr_r <= v_cnt_r[8:3];
            end
        end
    end

    // Timing delay line; visible only needs to reach the colour register input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vis_dl_r <= {(L-1){1'b0}};
            hs_dl_r  <= {L{1'b1}};
            vs_dl_r  <= {L{1'b1}};
            fs_dl_r  <= {L{1'b0}};
        end else begin
            vis_dl_r <= {vis_dl_r[L-3:0], visible_s};
            hs_dl_r  <= {hs_dl_r[L-2:0], hs_raw_s};
            vs_dl_r  <= {vs_dl_r[L-2:0], vs_raw_s};
            fs_dl_r  <= {fs_dl_r[L-2:0], first_px_s};
        end
    end

    // Colour register, blanked whenever the aligned pixel is off-screen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r <= 4'd0;
            g_r <= 4'd0;
            b_r <= 4'd0;
        end else if (vis_dl_r[L-2]) begin
            r_r <= bus.din[11:8];
            g_r <= bus.din[7:4];
            b_r <= bus.din[3:0];
        end else begin
            r_r <= 4'd0;
            g_r <= 4'd0;
            b_r <= 4'd0;
        end
    end

    assign bus.col_addr    = col_addr_r;
    assign bus.row_addr    = row_addr_r;
    assign bus.read_en     = read_en_r;
    assign bus.hs          = hs_dl_r[L-1];
    assign bus.vs          = vs_dl_r[L-1];
    assign bus.frame_start = fs_dl_r[L-1];
    assign bus.r           = r_r;
    assign bus.g           = g_r;
    assign bus.b           = b_r;
endmodule

// File: doc/vga_scan_reader.md
VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter RAM_LAT, default 1, pixel RAM read latency in cycles; legal values 1 or 2.
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst  in  1  reset; asynchronous assertion, active-low (0 = reset), synchronous deassertion assumed from the system.
REQ-008 din  in  12  pixel word from pixel RAM, {R[11:8], G[7:4], B[3:0]}.
REQ-009 col_addr  out  7  pixel RAM block column, 8-pixel-wide blocks.
REQ-010 row_addr  out  6  pixel RAM block row, 8-line-tall blocks.
REQ-011 read_en  out  1  high when col_addr/row_addr carry a valid visible-area read.
REQ-012 hs  out  1  horizontal sync, active-low.
REQ-013 vs  out  1  vertical sync, active-low.
REQ-014 r / g / b  out  4 each  colour outputs.
REQ-015 frame_start  out  1  one-cycle pulse at the first visible pixel of each frame (output-aligned).

Function
REQ-016 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800), wrapping to 0.
REQ-017 v_cnt SHALL increment only when h_cnt wraps, counting 0..V_TOTAL-1 (525), wrapping to 0 at the same edge h_cnt wraps.
REQ-018 Visible SHALL mean h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-019 Stage 1 (one cycle after counters): col_addr = h_cnt[9:3], row_addr = v_cnt[8:3], read_en = visible; all registered.
REQ-020 When not visible, col_addr and row_addr SHALL hold their last visible-area values.
REQ-021 din SHALL be sampled RAM_LAT cycles after stage 1; r/g/b registered from it one cycle later, total counter-to-colour latency L = 2 + RAM_LAT.
REQ-022 hs SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-023 hs, vs and the visible flag SHALL pass through an L-stage delay line so they are cycle-aligned with r/g/b.
REQ-024 r/g/b SHALL be forced to 0 whenever the delayed visible flag is 0, regardless of din.
REQ-025 frame_start SHALL pulse high for exactly one cycle, the cycle where r/g/b presents pixel (0,0).
REQ-026 Each block address SHALL be held constant for 8 consecutive visible pixels and 8 consecutive visible lines.
REQ-027 Block columns 80..127 and block rows 60..63 SHALL never be addressed at default parameters.
REQ-028 Block SHALL not write RAM or backpressure the writer; RAM is a free-running dual-port read.

Reset
REQ-029 While rst = 0: h_cnt = 0, v_cnt = 0, col_addr = 0, row_addr = 0, read_en = 0, r/g/b = 0, hs = 1, vs = 1, frame_start = 0, all delay-line stages cleared to the idle (non-visible, sync-high) value.
REQ-030 Reset mid-frame SHALL abort the frame immediately; first cycle after release restarts at h_cnt = 0, v_cnt = 0.
REQ-031 No colour SHALL be output during the first L cycles after release.

Verification
REQ-032 Release reset, din = 12'hF00 constant -> first r = 4'hF exactly L cycles after release, frame_start high same cycle; r = 0 for h_cnt 640..799.
REQ-033 Run one full frame -> hs low for 96 cycles starting 656 counts into each line, period 800; vs low for 2 lines (1600 cycles) starting at line 490; frame period 420000 cycles.
REQ-034 Model RAM with din = {col_addr[3:0], row_addr[3:0], 4'h0} at RAM_LAT = 1 -> pixel (x, y) shows r = (x>>3)&15, g = (y>>3)&15; addresses change every 8 pixels; max col_addr 79, max row_addr 59.
REQ-035 Assert rst at line 200 pixel 300 for 3 cycles -> all outputs at reset values within the asserting cycle, restart from (0,0), next frame_start exactly L cycles after release.
REQ-036 RAM_LAT = 2 -> all of REQ-032..034 hold with L = 4 and colour/sync still aligned.
